// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with hi/lo result registers.
// Multiplies use shift-add; divides use restoring division on magnitudes.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] os,
  input  logic [31:0] ot,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state;
  state_t      state_nx;
  logic [4:0]  cnt;
  logic        is_div;
  logic        neg_q;
  logic        rneg_q;
  logic        zero_q;
  logic [31:0] os_q;
  logic [31:0] m;
  logic [63:0] acc;

  logic        sgn_op;
  logic [31:0] os_mag;
  logic [31:0] ot_mag;
  logic [32:0] sum;
  logic [32:0] trial;
  logic [63:0] step;
  logic [63:0] prod;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (cnt == 5'd31) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb busy = (state != IDLE);

  assign sgn_op = ~op[0];
  assign os_mag = (sgn_op & os[31]) ? -os : os;
  assign ot_mag = (sgn_op & ot[31]) ? -ot : ot;

  // acc holds {partial product, multiplier} or {remainder, quotient}
  assign sum   = {1'b0, acc[63:32]} + {1'b0, m};
  assign trial = {acc[63:32], acc[31]} - {1'b0, m};

  always_comb begin
    step = acc;
    if (is_div) begin
      if (!trial[32]) step = {trial[31:0], acc[30:0], 1'b1};
      else            step = {acc[62:0], 1'b0};
    end else begin
      if (acc[0]) step = {sum, acc[31:1]};
      else        step = {1'b0, acc[63:32], acc[31:1]};
    end
  end

  always_comb begin
    prod   = neg_q ? -acc : acc;
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (is_div) begin
      if (zero_q) begin
        res_hi = os_q;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = rneg_q ? -acc[63:32] : acc[63:32];
        res_lo = neg_q  ? -acc[31:0]  : acc[31:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      zero_q <= 1'b0;
      os_q   <= '0;
      m      <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            neg_q  <= sgn_op & (os[31] ^ ot[31]);
            rneg_q <= sgn_op & os[31];
            zero_q <= (ot == '0);
            os_q   <= os;
            m      <= op[1] ? ot_mag : os_mag;
            acc    <= {32'b0, op[1] ? os_mag : ot_mag};
            cnt    <= '0;
          end else begin
            if (mthi) hi <= os;
            if (mtlo) lo <= os;
          end
        end
        CALC: begin
          acc <= step;
          cnt <= cnt + 5'd1;
        end
        FIX: begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_muldiv_unit;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] os;
  logic [31:0] ot;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int vectors = 0;
  int miscompares = 0;

  muldiv_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .os    (os),
    .ot    (ot),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts an op in the current cycle; returns in the done cycle.
  task automatic do_op(input logic [1:0] o, input logic [31:0] s,
                       input logic [31:0] t, input logic [31:0] eh,
                       input logic [31:0] el, input string tag);
    logic        ok;
    logic [31:0] h0;
    logic [31:0] l0;
    h0 = hi;
    l0 = lo;
    ok = 1'b1;
    start = 1'b1;
    op = o;
    os = s;
    ot = t;
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0;
        op = ~o;
        os = ~s;
        ot = ~t;
      end
      ok &= (busy === 1'b1) && (done === 1'b0) &&
            (hi === h0) && (lo === l0);
    end
    chk({tag, "_busy"}, {63'b0, ok}, 64'd1);
    @(negedge clk);
    chk({tag, "_done"}, {62'b0, done, busy}, 64'd2);
    chk({tag, "_res"}, {hi, lo}, {eh, el});
  endtask

  initial begin
    int ndone;
    rst = 1'b1;
    start = 1'b0;
    op = MULT;
    os = '0;
    ot = '0;
    mthi = 1'b0;
    mtlo = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset", {busy, done, hi, lo}, 66'd0);
    rst = 1'b0;

    // Back-to-back calls also start each op in the previous done cycle
    do_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
          32'hFFFFFFFE, 32'h00000001, "multu_max");
    do_op(MULT, 32'hFFFFFFFD, 32'h00000007,
          32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg");
    do_op(DIV, 32'hFFFFFFF9, 32'h00000002,
          32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
    do_op(DIVU, 32'd7, 32'd2, 32'd1, 32'd3, "divu_7_2");
    do_op(DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, "divu_zero");
    do_op(DIV, 32'h80000000, 32'hFFFFFFFF,
          32'h0, 32'h80000000, "div_ovf");
    do_op(MULT, 32'h80000000, 32'h80000000,
          32'h40000000, 32'h0, "mult_min");
    do_op(DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, "div_negdiv");

    // Stimulus disturbance while busy
    start = 1'b1;
    op = MULTU;
    os = 32'd3;
    ot = 32'd5;
    ndone = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
      if (k == 34) chk("dist_res", {done, hi, lo}, {1'b1, 32'd0, 32'd15});
      start = (k == 5);
      mthi = (k == 10);
      if (k == 1) begin
        op = DIV;
        os = 32'd100;
        ot = 32'd200;
      end
      if (k == 10) os = 32'hDEADBEEF;
    end
    chk("dist_pulses", 64'(ndone), 64'd1);
    start = 1'b0;
    mthi = 1'b0;

    mthi = 1'b1;
    mtlo = 1'b1;
    os = 32'h12345678;
    @(negedge clk);
    chk("move_both", {done, hi, lo}, {1'b0, 32'h12345678, 32'h12345678});
    mthi = 1'b0;
    start = 1'b1;
    op = MULTU;
    os = 32'd2;
    ot = 32'd3;
    @(negedge clk);
    start = 1'b0;
    mtlo = 1'b0;
    chk("move_vs_start", {busy, lo}, {1'b1, 32'h12345678});
    repeat (33) @(negedge clk);
    chk("move_op_res", {done, hi, lo}, {1'b1, 32'd0, 32'd6});

    // Asynchronous reset in the middle of a divide
    start = 1'b1;
    op = DIV;
    os = 32'd100;
    ot = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {busy, done, hi, lo}, 66'd0);
    ndone = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("rst_no_done", 64'(ndone), 64'd0);
    rst = 1'b0;
    do_op(MULTU, 32'd3, 32'd4, 32'd0, 32'h0000000C, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
